// File: rtl/alu_ctrl_seq.sv
// EX-stage control sequencer: combinational ALU/shifter/mux decode plus the multi-cycle MULTU FSM.
// Optional stall counter output is built only when ALU_CTRL_PERF_EN is defined.
module alu_ctrl_seq #(
  parameter int MULT_CYCLES = 32,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] operation,
  output logic       SignaltoMULTU,
  output logic       SignaltoSHT,
  output logic [1:0] SignaltoMUX,
  output logic       SignaltoHi,
  output logic       SignaltoLo,
  output logic       stall,
  output logic       busy,
  output logic       illegal
`ifdef ALU_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_HI  = 2'b01;
  localparam logic [1:0] MUX_LO  = 2'b10;
  localparam logic [1:0] MUX_SHT = 2'b11;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MULT_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_multu;

  assign w_multu = valid && (alu_op == 2'b10) && (funct == 6'd25);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_multu) begin
            r_state <= S_MUL;
            r_cnt   <= '0;
          end
        end
        S_MUL: begin
          if (r_cnt == LP_LAST) begin
            r_state <= S_WB;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WB:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are combinational so decode answers in the same cycle; rst overrides everything.
  always_comb begin
    operation     = OP_ADD;
    SignaltoMUX   = MUX_ALU;
    SignaltoSHT   = 1'b0;
    SignaltoMULTU = 1'b0;
    SignaltoHi    = 1'b0;
    SignaltoLo    = 1'b0;
    stall         = 1'b0;
    busy          = 1'b0;
    illegal       = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (valid) begin
            case (alu_op)
              2'b00: operation = OP_ADD;
              2'b01: operation = OP_SUB;
              2'b10: begin
                case (funct)
                  6'd36: operation = OP_AND;
                  6'd37: operation = OP_OR;
                  6'd32: operation = OP_ADD;
                  6'd34: operation = OP_SUB;
                  6'd42: operation = OP_SLT;
                  6'd0: begin
                    SignaltoSHT = 1'b1;
                    SignaltoMUX = MUX_SHT;
                  end
                  6'd16:   SignaltoMUX = MUX_HI;
                  6'd18:   SignaltoMUX = MUX_LO;
                  6'd8:    operation = OP_ADD;
                  6'd25:   stall = 1'b1;
                  default: illegal = 1'b1;
                endcase
              end
              default: illegal = 1'b1;
            endcase
          end
        end
        S_MUL: begin
          SignaltoMULTU = 1'b1;
          stall         = 1'b1;
          busy          = 1'b1;
        end
        S_WB: begin
          SignaltoHi = 1'b1;
          SignaltoLo = 1'b1;
          busy       = 1'b1;
        end
        default: busy = 1'b0;
      endcase
    end
  end

`ifdef ALU_CTRL_PERF_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: decode table, MULTU sequences, reset abort, random traffic.
module tb_alu_ctrl_seq;
  localparam int MC = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic [2:0] operation;
  logic       SignaltoMULTU, SignaltoSHT, SignaltoHi, SignaltoLo, stall, busy, illegal;
  logic [1:0] SignaltoMUX;
`ifdef ALU_CTRL_PERF_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  alu_ctrl_seq #(.MULT_CYCLES(MC), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .valid(valid), .alu_op(alu_op), .funct(funct),
    .operation(operation), .SignaltoMULTU(SignaltoMULTU), .SignaltoSHT(SignaltoSHT),
    .SignaltoMUX(SignaltoMUX), .SignaltoHi(SignaltoHi), .SignaltoLo(SignaltoLo),
    .stall(stall), .busy(busy), .illegal(illegal)
`ifdef ALU_CTRL_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  // Model: -1 when idle, otherwise cycles elapsed since the MULTU was accepted.
  int m_age = -1;
  int m_scnt = 0;
  logic [11:0] smp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Packing: {operation, MULTU, SHT, MUX, Hi, Lo, stall, busy, illegal}
  function automatic logic [11:0] model_out(input logic v, input logic [1:0] op,
                                            input logic [5:0] f, input logic r);
    logic [2:0] o; logic [1:0] mx; logic sh, mu, hl, st, bz, il;
    o = 3'd2; mx = 2'd0; sh = 0; mu = 0; hl = 0; st = 0; bz = 0; il = 0;
    if (!r) begin
      if (m_age >= 1 && m_age <= MC) begin
        mu = 1; st = 1; bz = 1;
      end else if (m_age == MC + 1) begin
        hl = 1; bz = 1;
      end else if (v) begin
        if (op == 2'd0) o = 3'd2;
        else if (op == 2'd1) o = 3'd6;
        else if (op == 2'd3) il = 1;
        else begin
          case (f)
            6'd36: o = 3'd0;
            6'd37: o = 3'd1;
            6'd32: o = 3'd2;
            6'd34: o = 3'd6;
            6'd42: o = 3'd7;
            6'd0:  begin sh = 1; mx = 2'd3; end
            6'd16: mx = 2'd1;
            6'd18: mx = 2'd2;
            6'd8:  o = 3'd2;
            6'd25: st = 1;
            default: il = 1;
          endcase
        end
      end
    end
    return {o, mu, sh, mx, hl, hl, st, bz, il};
  endfunction

  task automatic cyc(input logic v, input logic [1:0] op, input logic [5:0] f, input logic r);
    logic [11:0] e;
    valid = v; alu_op = op; funct = f; rst = r;
    @(negedge clk);
    e   = model_out(v, op, f, r);
    smp = {operation, SignaltoMULTU, SignaltoSHT, SignaltoMUX, SignaltoHi, SignaltoLo,
           stall, busy, illegal};
    chk("model", {20'd0, smp}, {20'd0, e});
`ifdef ALU_CTRL_PERF_EN
    chk("stall_cnt", {16'd0, stall_cnt}, m_scnt);
`endif
    @(posedge clk);
    if (r) begin
      m_age = -1; m_scnt = 0;
    end else begin
      if (e[2] && m_scnt != 32'hFFFF) m_scnt++;
      if (m_age < 0) begin
        if (v && op == 2'd2 && f == 6'd25) m_age = 1;
      end else if (m_age == MC + 1) m_age = -1;
      else m_age++;
    end
    #1;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [2:0] eop;
    logic [1:0] emux;
    logic       esht;
    logic       eill;
  } vec_t;

  vec_t tbl[12];
  int pool[12];

  initial begin
    int n_st, n_mu, n_hi;
    tbl[0]  = '{2'd2, 6'd36, 3'b000, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{2'd2, 6'd37, 3'b001, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{2'd2, 6'd32, 3'b010, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{2'd2, 6'd34, 3'b110, 2'b00, 1'b0, 1'b0};
    tbl[4]  = '{2'd2, 6'd42, 3'b111, 2'b00, 1'b0, 1'b0};
    tbl[5]  = '{2'd2, 6'd0,  3'b010, 2'b11, 1'b1, 1'b0};
    tbl[6]  = '{2'd2, 6'd16, 3'b010, 2'b01, 1'b0, 1'b0};
    tbl[7]  = '{2'd2, 6'd18, 3'b010, 2'b10, 1'b0, 1'b0};
    tbl[8]  = '{2'd2, 6'd8,  3'b010, 2'b00, 1'b0, 1'b0};
    tbl[9]  = '{2'd2, 6'd5,  3'b010, 2'b00, 1'b0, 1'b1};
    tbl[10] = '{2'd0, 6'd34, 3'b010, 2'b00, 1'b0, 1'b0};
    tbl[11] = '{2'd1, 6'd36, 3'b110, 2'b00, 1'b0, 1'b0};
    pool = '{36, 37, 32, 34, 42, 0, 16, 18, 8, 25, 25, 5};

    valid = 0; alu_op = 0; funct = 0; rst = 1;
    #1;
    // Reset held with a MULTU presented: nothing may start.
    cyc(1, 2'd2, 6'd25, 1);
    cyc(1, 2'd2, 6'd25, 1);
    chk("rst_outs", {20'd0, smp}, {20'd0, 3'b010, 9'd0});
    cyc(0, 2'd2, 6'd25, 0);
    chk("idle_after_rst", {31'd0, smp[1]}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      cyc(1, tbl[i].op, tbl[i].f, 0);
      chk("tbl", {25'd0, smp[11:9], smp[6:5], smp[7], smp[0]},
          {25'd0, tbl[i].eop, tbl[i].emux, tbl[i].esht, tbl[i].eill});
    end
    cyc(0, 2'd2, 6'd5, 0);
    chk("ill_pulse_end", {31'd0, smp[0]}, 32'd0);
    cyc(1, 2'd3, 6'd32, 0);
    chk("aluop11_ill", {31'd0, smp[0]}, 32'd1);

    // MULTU: instruction held while stalled, then MFHI follows.
    n_st = 0; n_mu = 0; n_hi = 0;
    for (int i = 0; i < MC + 2; i++) begin
      cyc(1, 2'd2, 6'd25, 0);
      n_st += int'(smp[2]); n_mu += int'(smp[8]); n_hi += int'(smp[4] & smp[3]);
      if (i == MC + 1) chk("wb_no_stall", {31'd0, smp[2]}, 32'd0);
    end
    chk("stall_cycles", n_st, 33);
    chk("multu_cycles", n_mu, MC);
    chk("hilo_strobes", n_hi, 1);
    cyc(1, 2'd2, 6'd16, 0);
    chk("mfhi_mux", {30'd0, smp[6:5]}, 32'd1);
    chk("mfhi_no_strobe", {30'd0, smp[4:3]}, 32'd0);

    // Reset at MUL cycle 10: abort, no strobe ever.
    cyc(1, 2'd2, 6'd25, 0);
    for (int i = 0; i < 10; i++) cyc(0, 2'd0, 6'd0, 0);
    cyc(1, 2'd2, 6'd25, 1);
    cyc(0, 2'd0, 6'd0, 0);
    chk("abort_idle", {30'd0, smp[8], smp[1]}, 32'd0);
    n_hi = 0;
    for (int i = 0; i < MC + 4; i++) begin
      cyc(0, 2'd0, 6'd0, 0);
      n_hi += int'(smp[4] | smp[3]);
    end
    chk("abort_no_strobe", n_hi, 0);

    // Back-to-back MULTU, counters cleared first.
    cyc(0, 2'd0, 6'd0, 1);
    n_mu = 0;
    for (int i = 0; i < 2 * (MC + 2); i++) begin
      cyc(1, 2'd2, 6'd25, 0);
      n_mu += int'(smp[8]);
    end
    cyc(0, 2'd0, 6'd0, 0);
    chk("b2b_multu", n_mu, 2 * MC);
`ifdef ALU_CTRL_PERF_EN
    chk("b2b_stall_cnt", {16'd0, stall_cnt}, 32'd66);
    cyc(0, 2'd0, 6'd0, 1);
    cyc(0, 2'd0, 6'd0, 0);
    chk("stall_cnt_clr", {16'd0, stall_cnt}, 32'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
          6'(pool[$urandom_range(0, 11)]), 1'($urandom_range(0, 60) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
